// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared register-id types and writeback arbitration types
package params_pkg;

  localparam int REG_ID_W = 5;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  localparam reg_id_t X0 = '0;

  localparam int WB_XLEN = 32;

  typedef enum logic {
    PRIO_EX  = 1'b0,
    PRIO_ALU = 1'b1
  } wb_prio_t;

  typedef struct packed {
    logic                req;
    reg_id_t             wr_reg;
    logic [WB_XLEN-1:0]  wr_data;
  } wb_req_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// rtl/wb_starve_ctr.sv - ALU/MEM starvation counter and writeback priority FSM
module wb_starve_ctr
  import params_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_req,
  input  logic alu_grant,
  output logic prio_alu,
  output logic switch_pulse
);

  localparam logic [CNT_W:0]   LIMIT_EXT = (CNT_W+1)'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  wb_prio_t          prio_q, prio_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [CNT_W:0]    starve_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= PRIO_EX;
      starve_q <= '0;
    end else begin
      prio_q   <= prio_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    starve_inc   = {1'b0, starve_q} + {{CNT_W{1'b0}}, 1'b1};
    starve_d     = '0;
    prio_d       = prio_q;
    switch_pulse = 1'b0;
    if (alu_req && !alu_grant) begin
      starve_d = (starve_inc >= LIMIT_EXT) ? LIMIT_CNT : starve_inc[CNT_W-1:0];
      if (prio_q == PRIO_EX && starve_inc == LIMIT_EXT) begin
        prio_d       = PRIO_ALU;
        switch_pulse = 1'b1;
      end
    end
    // ALU priority lasts exactly until it is served or withdraws its request
    if (prio_q == PRIO_ALU && (alu_grant || !alu_req)) begin
      prio_d = PRIO_EX;
    end
  end

  assign prio_alu = (prio_q == PRIO_ALU);

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - RF write-port arbiter between ALU/MEM and EX5; WB_ARB_STATS_EN adds counters
module wb_arbiter
  import params_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_req_i,
  input  reg_id_t         alu_wr_reg_i,
  input  logic [XLEN-1:0] alu_wr_data_i,
  input  logic            ex_req_i,
  input  reg_id_t         ex_wr_reg_i,
  input  logic [XLEN-1:0] ex_wr_data_i,
  output logic            alu_allowed_wb_o,
  output logic            ex_allowed_wb_o,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]     stat_conflict_o,
  output logic [31:0]     stat_alu_stall_o,
  output logic [31:0]     stat_starve_switch_o,
`endif
  output logic            rf_wr_en_o,
  output reg_id_t         rf_wr_reg_o,
  output logic [XLEN-1:0] rf_wr_data_o
);

  logic    prio_alu;
  logic    switch_pulse;
  logic    alu_grant, ex_grant;
  wb_req_t alu_r, ex_r, win;

  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk          (clk_i),
    .rst          (rst_i),
    .alu_req      (alu_req_i),
    .alu_grant    (alu_grant),
    .prio_alu     (prio_alu),
    .switch_pulse (switch_pulse)
  );

  assign alu_grant = !rst_i && alu_req_i && (!ex_req_i || prio_alu);
  assign ex_grant  = !rst_i && ex_req_i && (!alu_req_i || !prio_alu);

  assign alu_allowed_wb_o = alu_grant;
  assign ex_allowed_wb_o  = ex_grant;

  always_comb begin
    alu_r = '{req: alu_req_i, wr_reg: alu_wr_reg_i, wr_data: alu_wr_data_i};
    ex_r  = '{req: ex_req_i,  wr_reg: ex_wr_reg_i,  wr_data: ex_wr_data_i};
    win   = '0;
    if (alu_grant) begin
      win = alu_r;
    end else if (ex_grant) begin
      win = ex_r;
    end
  end

  // X0 writes still consume the slot but never assert the enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_wr_en_o   <= 1'b0;
      rf_wr_reg_o  <= '0;
      rf_wr_data_o <= '0;
    end else begin
      rf_wr_en_o <= win.req && (win.wr_reg != X0);
      if (win.req) begin
        rf_wr_reg_o  <= win.wr_reg;
        rf_wr_data_o <= win.wr_data;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_conflict_o      <= '0;
      stat_alu_stall_o     <= '0;
      stat_starve_switch_o <= '0;
    end else begin
      if (alu_req_i && ex_req_i) stat_conflict_o <= stat_conflict_o + 32'd1;
      if (alu_req_i && !alu_grant) stat_alu_stall_o <= stat_alu_stall_o + 32'd1;
      if (switch_pulse) stat_starve_switch_o <= stat_starve_switch_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Arbitrates the single register-file write port between two producers: the ALU/MEM path and the multiply pipeline (EX5 stage).
- Produces the per-cycle write permissions `alu_allowed_wb_o` and `ex_allowed_wb_o`, which the hazard unit consumes to stall the losing path.
- Registers the winning write into the RF write port.
- A starvation counter bounds how long the ALU/MEM path can lose to the multiply pipeline.

Parameters:
- XLEN, 32, data width of the writeback value.
- STARVE_LIMIT, 4, consecutive denied ALU/MEM request cycles before ALU/MEM gets priority; legal range 1..15.
- CNT_W, 4, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- alu_req_i  in  1  ALU/MEM path has a finishing instruction needing writeback.
- alu_wr_reg_i  in  reg_id_t  destination register of the ALU/MEM request.
- alu_wr_data_i  in  XLEN  ALU/MEM writeback value.
- ex_req_i  in  1  EX5 holds a valid multiply result.
- ex_wr_reg_i  in  reg_id_t  destination register of the EX5 result.
- ex_wr_data_i  in  XLEN  EX5 writeback value.
- alu_allowed_wb_o  out  1  ALU/MEM request granted this cycle (combinational).
- ex_allowed_wb_o  out  1  EX5 request granted this cycle (combinational).
- rf_wr_en_o  out  1  registered RF write enable.
- rf_wr_reg_o  out  reg_id_t  registered RF write address.
- rf_wr_data_o  out  XLEN  registered RF write data.

Behaviour:
- State:
  - `prio_q` is of type `wb_prio_t`: PRIO_EX or PRIO_ALU. Reset value is PRIO_EX.
  - `starve_q` is CNT_W bits. Reset value is 0.
- Grant (combinational, same cycle as the request):
  - Single requester: that requester is granted.
  - Both requesting: the requester selected by `prio_q` wins.
  - No requester: both allowed outputs are 0.
  - At most one allowed output is high in any cycle.
- Allowed outputs without a request: each `*_allowed_wb_o` is 0 when its own request is 0. The hazard unit gates these outputs with the valid signals.
- Starvation counter:
  - If `alu_req_i` is high and ALU is not granted: `starve_q` increments, saturating at STARVE_LIMIT.
  - If ALU is granted or `alu_req_i` is low: `starve_q` clears to 0.
- FSM transitions:
  - PRIO_EX -> PRIO_ALU when the incremented `starve_q` equals STARVE_LIMIT. The switch takes effect the cycle after the Nth consecutive denial.
  - PRIO_ALU -> PRIO_EX in the cycle after ALU is granted.
  - If `alu_req_i` drops while in PRIO_ALU, the FSM returns to PRIO_EX on the next edge.
- Write port:
  - On each edge, `rf_wr_en_o` <= (any grant) && (granted destination != X0).
  - `rf_wr_reg_o` and `rf_wr_data_o` load the granted request's register and data.
  - When there is no grant, address and data hold their previous values.
  - Latency from grant to RF write is one cycle.
- X0 writes: a request targeting X0 is still arbitrated and granted. It consumes the slot but produces `rf_wr_en_o` = 0.
- Reset:
  - All registered outputs go to 0, `prio_q` to PRIO_EX, `starve_q` to 0.
  - A reset asserted mid-stream discards the pending registered write. Allowed outputs are forced to 0 during reset.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, three 32-bit wrapping counters are added, each reset to 0:
  - `stat_conflict_o`: cycles with both requests high.
  - `stat_alu_stall_o`: ALU/MEM denied cycles.
  - `stat_starve_switch_o`: PRIO_EX -> PRIO_ALU transitions.
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Decomposition:
- `params_pkg` gains:
  - `wb_prio_t` enum (PRIO_EX, PRIO_ALU).
  - `wb_req_t` struct {req, wr_reg, wr_data}.
- `params_pkg` already provides `reg_id_t` and X0, which are reused.
- One sub-module, `wb_starve_ctr`: the saturating counter plus the PRIO FSM. It outputs `prio_alu`. The top level keeps the grant mux and the write register.

Test Plan:
1. ALU only: `alu_req_i` = 1, rd = 5, data 0xDEAD -> `alu_allowed_wb_o` = 1 the same cycle; next cycle `rf_wr_en_o` = 1, reg 5, data 0xDEAD.
2. Both requesting after reset (ex rd = 7, data 0x11; alu rd = 3) -> EX granted; next cycle RF reg 7, data 0x11; `alu_allowed_wb_o` = 0.
3. Both requesting continuously with STARVE_LIMIT = 4 -> EX wins cycles 0–3; ALU wins cycle 4; EX wins cycle 5; ALU wins again in cycle 9.
4. ALU request targeting X0 -> `alu_allowed_wb_o` = 1; next cycle `rf_wr_en_o` = 0; `starve_q` clears.
5. Reset asserted in cycle 2 of a 4-cycle conflict -> next cycle `rf_wr_en_o` = 0, `prio_q` = PRIO_EX, `starve_q` = 0; EX wins the first conflict after reset.
6. With WB_ARB_STATS_EN defined, 10 conflict cycles -> `stat_conflict_o` = 10, `stat_alu_stall_o` = 8, `stat_starve_switch_o` = 2.
